// File: rtl/gated_sr_pkg.sv
// gated_sr_pkg: shared definitions for the gated SR storage bank.
//   - MODE_*  : encodings for resolving a qualified S=R=1 command
//   - cmd_t   : per-channel command {S,R}
//   - popcount32 : number of ones in a 32-bit vector
package gated_sr_pkg;

  localparam int MODE_SET_DOM = 0;
  localparam int MODE_RST_DOM = 1;
  localparam int MODE_HOLD    = 2;
  localparam int MODE_TOGGLE  = 3;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RST  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_BOTH = 2'b11
  } cmd_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sr_filter_cell.sv
// sr_filter_cell: one clocked SR cell with input qualification filter.
//   clk, rst      : clock and synchronous active-high reset
//   en            : gate; low clears the stable count
//   s, r          : set / reset request
//   q             : stored state (registered)
//   conflict_qual : high in the cycle an S=R=1 command qualifies; it is
//                   captured by the parent on the same edge as the Q action
module sr_filter_cell
  import gated_sr_pkg::*;
#(
  parameter int MODE   = MODE_SET_DOM,
  parameter int FILTER = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q,
  output logic conflict_qual
);

  localparam logic [3:0] FILT = 4'(FILTER);

  cmd_t       cmd;
  cmd_t       last_cmd;
  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       qual;
  logic       q_next;

  always_comb begin
    cmd      = cmd_t'({s, r});
    cnt_next = cnt;
    q_next   = q;

    if (!en || cmd == CMD_IDLE) begin
      cnt_next = '0;
    end else if (cmd != last_cmd) begin
      cnt_next = 4'd1;
    end else if (cnt < FILT) begin
      cnt_next = cnt + 4'd1;
    end

    // Qualify only on the first cycle the count reaches FILTER; a run that
    // is already saturated on the same command stays silent.
    qual = (cnt_next == FILT) && !(cmd == last_cmd && cnt == FILT);

    if (qual) begin
      case (cmd)
        CMD_SET: q_next = 1'b1;
        CMD_RST: q_next = 1'b0;
        CMD_BOTH: begin
          case (MODE)
            MODE_SET_DOM: q_next = 1'b1;
            MODE_RST_DOM: q_next = 1'b0;
            MODE_TOGGLE:  q_next = ~q;
            default:      q_next = q;
          endcase
        end
        default: q_next = q;
      endcase
    end

    conflict_qual = qual && (cmd == CMD_BOTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      last_cmd <= CMD_IDLE;
      q        <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      last_cmd <= cmd;
      q        <= q_next;
    end
  end

endmodule

// File: rtl/gated_sr_bank.sv
// gated_sr_bank: CHANNELS independent filtered SR cells with conflict tracking.
//   CLK, RST     : clock and synchronous active-high reset
//   EN           : gate for all channels
//   S, R         : per-channel set / reset requests
//   CLR_CONFLICT : clears CONFLICT and CONFLICT_CNT (new conflicts win)
//   Q, P         : stored state and its complement
//   CONFLICT     : sticky per-channel S=R=1 qualification flag
//   CONFLICT_CNT : saturating total of qualified conflicts
module gated_sr_bank
  import gated_sr_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int MODE     = MODE_SET_DOM,
  parameter int FILTER   = 2,
  parameter int CNT_W    = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [CHANNELS-1:0] S,
  input  logic [CHANNELS-1:0] R,
  input  logic                CLR_CONFLICT,
  output logic [CHANNELS-1:0] Q,
  output logic [CHANNELS-1:0] P,
  output logic [CHANNELS-1:0] CONFLICT,
  output logic [CNT_W-1:0]    CONFLICT_CNT
);

  logic [CHANNELS-1:0] q_int;
  logic [CHANNELS-1:0] qual;
  logic [31:0]         qual_ext;
  logic [5:0]          pop;
  logic [CNT_W+5:0]    sum;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    cnt_base;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    sr_filter_cell #(
      .MODE   (MODE),
      .FILTER (FILTER)
    ) u_cell (
      .clk           (CLK),
      .rst           (RST),
      .en            (EN),
      .s             (S[i]),
      .r             (R[i]),
      .q             (q_int[i]),
      .conflict_qual (qual[i])
    );
  end

  always_comb begin
    qual_ext                 = '0;
    qual_ext[CHANNELS-1:0]   = qual;
    pop                      = popcount32(qual_ext);
    // A clear restarts the total from zero, then this cycle's conflicts add in.
    cnt_base                 = CLR_CONFLICT ? '0 : CONFLICT_CNT;
    sum                      = (CNT_W+6)'(cnt_base) + (CNT_W+6)'(pop);
    if (sum > (CNT_W+6)'({CNT_W{1'b1}})) begin
      cnt_next = '1;
    end else begin
      cnt_next = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      CONFLICT     <= '0;
      CONFLICT_CNT <= '0;
    end else begin
      CONFLICT     <= (CLR_CONFLICT ? '0 : CONFLICT) | qual;
      CONFLICT_CNT <= cnt_next;
    end
  end

  // Q is registered inside the cells, so P carries no input-to-output path.
  assign Q = q_int;
  assign P = ~q_int;

endmodule

// File: doc/gated_sr_bank.md
# gated_sr_bank

Parametrised bank of clocked SR storage cells that generalises the single gated SR latch to CHANNELS independent, fully synchronous cells. It adds a selectable S=R=1 resolution mode, a per-channel input qualification filter, and conflict tracking. It sits between raw control/status strobes and downstream logic that needs glitch-free, deterministic set/reset state with complementary outputs.

## Interface
- CHANNELS, 8: number of independent SR cells (1..32).
- MODE, 0: S=R=1 resolution. 0 = set-dominant, 1 = reset-dominant, 2 = hold, 3 = toggle (JK behaviour).
- FILTER, 2: consecutive enabled cycles a command must be stable before it acts (1..15; 1 = no filtering).
- CNT_W, 8: width of the conflict counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN  in  1  gate; when low, commands are ignored and all filter counts clear.
- S  in  CHANNELS  per-channel set request.
- R  in  CHANNELS  per-channel reset request.
- CLR_CONFLICT  in  1  clears CONFLICT and CONFLICT_CNT.
- Q  out  CHANNELS  stored state.
- P  out  CHANNELS  complement; always equals ~Q, with no cycle of disagreement.
- CONFLICT  out  CHANNELS  sticky flag; set when the channel qualifies an S=R=1 command.
- CONFLICT_CNT  out  CNT_W  total qualified conflicts across all channels; saturates at all-ones.

## Operation
- Per channel, the command is {S,R}. The filter keeps the last command and a stable count, 0..FILTER.
- Count update, in priority order:
  - RST: count = 0.
  - EN=0: count = 0.
  - Command 00: count = 0.
  - Command differs from the previous cycle's command: count = 1.
  - Otherwise: count increments, saturating at FILTER.
- A command qualifies only on the cycle its count first reaches FILTER. That is once per stable run: holding S high sets once, and in toggle mode it toggles once.
- Qualified actions:
  - 10: Q = 1.
  - 01: Q = 0.
  - 11: resolved per MODE (set / reset / hold / invert). In every mode it also raises CONFLICT[i].
- Changing directly from 10 to 11 restarts the count. The 11 command must itself be stable for FILTER cycles.
- CONFLICT_CNT adds the popcount of channels that qualify 11 in that cycle, then saturates.
- CLR_CONFLICT in the same cycle as new conflicts: the new conflicts win. The flags of newly conflicting channels are set, and the counter loads the new popcount.
- Channels are fully independent. Only CONFLICT_CNT is shared.

## Timing
- Reset values: Q = 0, P = all ones, CONFLICT = 0, CONFLICT_CNT = 0, filter state cleared.
- RST has priority over EN, commands and CLR_CONFLICT.
- RST asserted mid-filter abandons the partial count; no action follows.
- Latency: a command first sampled at edge k updates Q at edge k+FILTER-1. With FILTER=1, Q changes at the sampling edge, i.e. visible one cycle after the command.
- CONFLICT and CONFLICT_CNT update on the same edge as the Q action.
- EN dropping for one cycle mid-run restarts qualification from zero.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package gated_sr_pkg holds:
  - MODE encodings as named constants: MODE_SET_DOM, MODE_RST_DOM, MODE_HOLD, MODE_TOGGLE.
  - A command type for {S,R}.
- Sub-module sr_filter_cell, instantiated once per channel:
  - Owns the filter counter, last command and Q.
  - Outputs Q and a one-cycle conflict-qualified pulse.
- The top level holds the popcount, saturating CONFLICT_CNT, sticky CONFLICT flags and P = ~Q.

## Test plan
- Reset: assert RST with S/R toggling -> Q=0, P=all ones, CONFLICT=0, CNT=0. Release, then S[0]=1 for 2 cycles (FILTER=2) -> Q[0]=1 after the second edge only.
- Glitch rejection: S[3] high for 1 cycle with FILTER=2 -> Q[3] stays 0. R[3] high for 3 cycles after Q[3]=1 -> Q[3]=0 after the second cycle and unchanged after the third.
- Each MODE in turn: from Q=0, apply S=R=1 on channel 1 for FILTER cycles -> Q[1] = 1 / 0 / 0 / 1, and CONFLICT[1]=1 in all modes. Toggle mode held 10 more cycles -> Q[1] stays 1 (single toggle).
- Counter: CNT_W=2, three channels qualify 11 in the same cycle, then two more later -> CNT=3 then saturates at 3. CLR_CONFLICT together with one new conflict -> CNT=1, and only that channel's flag is set.
- Gating: EN dropped for 1 cycle in the middle of a 2-cycle S run -> no set. S held 2 more enabled cycles -> set. Command change 10->11 restarts the count (Q follows the 10 command only if it was already qualified).
